pwm_multiphase_gen: RTL and testbench

//  Synthesizable N-channel gate-drive generator. It is the parametrised successor of the fixed

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_deadtime.sv | 92 +++++++++
 rtl/pwm_multiphase_gen.sv | 127 ++++++++++++
 tb/tb_pwm_multiphase_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multiphase PWM generator.
// The counter and dead-time widths live here so the top, the dead-time channels and any
// consumer all agree on one set of types.
package pwm_pkg;

   localparam int unsigned CNT_W = 16;
   localparam int unsigned DT_W  = 8;

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [DT_W-1:0]  dt_t;
   // One extra bit so cnt + phase cannot overflow before the wrap subtraction.
   typedef logic [CNT_W:0]   pos_t;

   // Phase-shifted counter position, folded back into 0..period.
   function automatic pos_t wrap_pos(input cnt_t cnt, input cnt_t ph, input cnt_t period);
      pos_t pos;
      pos_t lim;
      pos = {1'b0, cnt} + {1'b0, ph};
      lim = {1'b0, period} + pos_t'(1);
      if (pos >= lim) begin
         pos = pos - lim;
      end
      return pos;
   endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time inserter for one PWM channel.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           run enable; low forces both outputs off and preloads the counter
//   raw_i          registered raw PWM level from the compare stage
//   dead_time_i    cycles both sides stay low after every raw edge
//   hi_o, lo_o     complementary gate drives, never high together
module pwm_deadtime
   import pwm_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic raw_i,
   input  dt_t  dead_time_i,
   output logic hi_o,
   output logic lo_o
);

   localparam logic [1:0] StOff    = 2'd0;
   localparam logic [1:0] StHiWait = 2'd1;
   localparam logic [1:0] StLoWait = 2'd2;
   localparam logic [1:0] StDrive  = 2'd3;

   logic [1:0] state_q, state_d;
   logic       lvl_q, lvl_d;
   dt_t        dcnt_q, dcnt_d;
   logic       hi_q, hi_d;
   logic       lo_q, lo_d;

   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      dcnt_d  = dcnt_q;
      hi_d    = 1'b0;
      lo_d    = 1'b0;
      if (!en_i) begin
         state_d = StOff;
         dcnt_d  = dead_time_i;
      end else if ((state_q == StOff) || (raw_i != lvl_q)) begin
         // Any raw edge (or leaving idle) drops both sides and restarts the dead time.
         lvl_d  = raw_i;
         dcnt_d = dead_time_i;
         if (dead_time_i == '0) begin
            state_d = StDrive;
            hi_d    = raw_i;
            lo_d    = ~raw_i;
         end else begin
            state_d = raw_i ? StHiWait : StLoWait;
         end
      end else begin
         unique case (state_q)
            StHiWait, StLoWait: begin
               if (dcnt_q <= dt_t'(1)) begin
                  state_d = StDrive;
                  hi_d    = lvl_q;
                  lo_d    = ~lvl_q;
               end else begin
                  dcnt_d = dcnt_q - dt_t'(1);
               end
            end
            StDrive: begin
               hi_d = lvl_q;
               lo_d = ~lvl_q;
            end
            default: begin
               state_d = StOff;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StOff;
         lvl_q   <= 1'b0;
         dcnt_q  <= '0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lvl_q   <= lvl_d;
         dcnt_q  <= dcnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/pwm_multiphase_gen.sv
// N-channel phase-shifted PWM gate-drive generator with shadowed configuration.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   en_i                  run enable; low = idle, counter at 0, outputs low
//   load_i                1-cycle request to capture the config inputs into shadow
//   period_i              cycles per period minus 1
//   duty_i, phase_i       per-channel high time / counter offset, ch i at [i*CNT_W +: CNT_W]
//   dead_time_i           dead-time cycles shared by all channels
//   ctrl_hi_o, ctrl_lo_o  complementary drives per channel
//   cycle_start_o         registered pulse when the counter is at 0
//   pending_o             shadow holds a config not yet active
module pwm_multiphase_gen
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [CNT_W-1:0]      period_i,
   input  logic [N_CH*CNT_W-1:0] duty_i,
   input  logic [N_CH*CNT_W-1:0] phase_i,
   input  logic [DT_W-1:0]       dead_time_i,
   output logic [N_CH-1:0]       ctrl_hi_o,
   output logic [N_CH-1:0]       ctrl_lo_o,
   output logic                  cycle_start_o,
   output logic                  pending_o
);

   cnt_t                  period_sh_q, period_sh_d, period_act_q, period_act_d;
   logic [N_CH*CNT_W-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;
   logic [N_CH*CNT_W-1:0] phase_sh_q, phase_sh_d, phase_act_q, phase_act_d;
   dt_t                   dt_sh_q, dt_sh_d, dt_act_q, dt_act_d;
   logic                  pending_q, pending_d;
   cnt_t                  cnt_q, cnt_d;
   logic                  cs_q, cs_d;
   logic [N_CH-1:0]       raw_q, raw_d;
   logic                  wrap, apply;

   always_comb begin
      wrap  = en_i && (cnt_q == period_act_q);
      apply = wrap || !en_i;

      period_sh_d = load_i ? period_i    : period_sh_q;
      duty_sh_d   = load_i ? duty_i      : duty_sh_q;
      phase_sh_d  = load_i ? phase_i     : phase_sh_q;
      dt_sh_d     = load_i ? dead_time_i : dt_sh_q;

      // Sourcing from the *_d shadow lets a load coinciding with the wrap take effect there.
      period_act_d = apply ? period_sh_d : period_act_q;
      duty_act_d   = apply ? duty_sh_d   : duty_act_q;
      phase_act_d  = apply ? phase_sh_d  : phase_act_q;
      dt_act_d     = apply ? dt_sh_d     : dt_act_q;

      if (apply) begin
         pending_d = 1'b0;
      end else if (load_i) begin
         pending_d = 1'b1;
      end else begin
         pending_d = pending_q;
      end

      cnt_d = (!en_i || wrap) ? '0 : cnt_q + cnt_t'(1);
      cs_d  = en_i && (cnt_q == '0);
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      cnt_t duty_c;
      cnt_t phase_c;
      cnt_t ph_c;
      pos_t pos_c;

      assign duty_c  = duty_act_q[i*CNT_W +: CNT_W];
      assign phase_c = phase_act_q[i*CNT_W +: CNT_W];
      assign ph_c    = (phase_c > period_act_q) ? period_act_q : phase_c;
      assign pos_c   = wrap_pos(cnt_q, ph_c, period_act_q);
      assign raw_d[i] = (pos_c < {1'b0, duty_c});

      pwm_deadtime u_deadtime (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .en_i        (en_i),
         .raw_i       (raw_q[i]),
         .dead_time_i (dt_act_q),
         .hi_o        (ctrl_hi_o[i]),
         .lo_o        (ctrl_lo_o[i])
      );
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         period_sh_q  <= '0;
         duty_sh_q    <= '0;
         phase_sh_q   <= '0;
         dt_sh_q      <= '0;
         period_act_q <= '0;
         duty_act_q   <= '0;
         phase_act_q  <= '0;
         dt_act_q     <= '0;
         pending_q    <= 1'b0;
         cnt_q        <= '0;
         cs_q         <= 1'b0;
         raw_q        <= '0;
      end else begin
         period_sh_q  <= period_sh_d;
         duty_sh_q    <= duty_sh_d;
         phase_sh_q   <= phase_sh_d;
         dt_sh_q      <= dt_sh_d;
         period_act_q <= period_act_d;
         duty_act_q   <= duty_act_d;
         phase_act_q  <= phase_act_d;
         dt_act_q     <= dt_act_d;
         pending_q    <= pending_d;
         cnt_q        <= cnt_d;
         cs_q         <= cs_d;
         raw_q        <= raw_d;
      end
   end

   assign cycle_start_o = cs_q;
   assign pending_o     = pending_q;

   a_no_shoot_through: assert property (@(posedge clk_i) disable iff (!rst_ni)
      ((ctrl_hi_o & ctrl_lo_o) == '0));

endmodule

// File: tb/tb_pwm_multiphase_gen.sv
`timescale 1ns/1ps
module tb_pwm_multiphase_gen;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        en;
   logic        load;
   logic [15:0] period;
   logic [63:0] duty;
   logic [63:0] phase;
   logic [7:0]  dead_time;
   logic [3:0]  ctrl_hi;
   logic [3:0]  ctrl_lo;
   logic        cycle_start;
   logic        pending;

   int n_checks = 0;
   int n_errors = 0;

   int hi_cnt [4];
   int lo_cnt [4];
   int rise   [4];
   int both_lo_cnt;
   int overlap_cnt;
   int shoot_cnt;
   int cs_cnt;

   always #5 clk = ~clk;

   pwm_multiphase_gen #(.N_CH(4)) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .en_i          (en),
      .load_i        (load),
      .period_i      (period),
      .duty_i        (duty),
      .phase_i       (phase),
      .dead_time_i   (dead_time),
      .ctrl_hi_o     (ctrl_hi),
      .ctrl_lo_o     (ctrl_lo),
      .cycle_start_o (cycle_start),
      .pending_o     (pending)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      return {16'(d), 16'(c), 16'(b), 16'(a)};
   endfunction

   // Idle, load a config while disabled (applies at once), then enable.
   task automatic configure(input int per, input logic [63:0] du, input logic [63:0] ph,
                            input int dt);
      en = 1'b0;
      repeat (3) step();
      load      = 1'b1;
      period    = 16'(per);
      duty      = du;
      phase     = ph;
      dead_time = 8'(dt);
      step();
      load = 1'b0;
      step();
      en = 1'b1;
   endtask

   task automatic measure(input int n);
      logic [3:0] prev;
      both_lo_cnt = 0;
      overlap_cnt = 0;
      shoot_cnt   = 0;
      cs_cnt      = 0;
      for (int c = 0; c < 4; c++) begin
         hi_cnt[c] = 0;
         lo_cnt[c] = 0;
         rise[c]   = -1;
      end
      prev = ctrl_hi;
      for (int k = 0; k < n; k++) begin
         step();
         for (int c = 0; c < 4; c++) begin
            hi_cnt[c] += int'(ctrl_hi[c]);
            lo_cnt[c] += int'(ctrl_lo[c]);
            if (c == 0 && !ctrl_hi[0] && !ctrl_lo[0]) both_lo_cnt++;
            if (ctrl_hi[c] && !prev[c] && rise[c] < 0) rise[c] = k;
         end
         if ($countones(ctrl_hi) > 1) overlap_cnt++;
         if ((ctrl_hi & ctrl_lo) != 4'h0) shoot_cnt++;
         cs_cnt += int'(cycle_start);
         prev = ctrl_hi;
      end
   endtask

   task automatic wait_hi0(input string tag);
      int k;
      k = 0;
      while (!ctrl_hi[0] && k < 100) begin
         step();
         k++;
      end
      check_eq(tag, 32'(ctrl_hi[0]), 32'd1);
   endtask

   initial begin
      rst_ni    = 1'b0;
      en        = 1'b0;
      load      = 1'b0;
      period    = '0;
      duty      = '0;
      phase     = '0;
      dead_time = '0;
      repeat (3) step();
      check_eq("rst_hi", 32'(ctrl_hi), 32'd0);
      check_eq("rst_lo", 32'(ctrl_lo), 32'd0);
      check_eq("rst_cs", 32'(cycle_start), 32'd0);
      check_eq("rst_pending", 32'(pending), 32'd0);
      rst_ni = 1'b1;
      step();

      // 1: 50% duty, period 100, no dead time
      configure(99, pack4(50, 50, 50, 50), pack4(0, 0, 0, 0), 0);
      repeat (10) step();
      measure(200);
      check_eq("t1_hi_cycles", 32'(hi_cnt[0]), 32'd100);
      check_eq("t1_lo_cycles", 32'(lo_cnt[0]), 32'd100);
      check_eq("t1_cycle_start", 32'(cs_cnt), 32'd2);
      check_eq("t1_shoot", 32'(shoot_cnt), 32'd0);

      // 2: four quarter-period phases
      configure(99, pack4(25, 25, 25, 25), pack4(0, 25, 50, 75), 0);
      repeat (10) step();
      measure(200);
      for (int c = 0; c < 4; c++) begin
         check_eq($sformatf("t2_hi_cycles_ch%0d", c), 32'(hi_cnt[c]), 32'd50);
      end
      check_eq("t2_overlap", 32'(overlap_cnt), 32'd0);
      for (int c = 1; c < 4; c++) begin
         check_eq($sformatf("t2_rise_ch%0d", c), 32'((rise[c] - rise[0] + 200) % 100),
                  32'((75 * c) % 100));
      end

      // 3: dead time 3 on a 20-cycle period
      configure(19, pack4(10, 10, 10, 10), pack4(0, 0, 0, 0), 3);
      repeat (30) step();
      measure(40);
      check_eq("t3_hi_cycles", 32'(hi_cnt[0]), 32'd14);
      check_eq("t3_lo_cycles", 32'(lo_cnt[0]), 32'd14);
      check_eq("t3_both_low", 32'(both_lo_cnt), 32'd12);
      check_eq("t3_shoot", 32'(shoot_cnt), 32'd0);

      // 4: mid-period load at cnt 8 waits for the wrap
      begin
         int k;
         k = 0;
         while (!cycle_start && k < 40) begin
            step();
            k++;
         end
         check_eq("t4_found_start", 32'(cycle_start), 32'd1);
      end
      repeat (7) step();                 // cnt == 8
      load = 1'b1;
      duty = pack4(5, 5, 5, 5);
      step();                            // cnt == 9
      load = 1'b0;
      check_eq("t4_pending_set", 32'(pending), 32'd1);
      repeat (2) step();                 // cnt == 11, old duty still drives hi
      check_eq("t4_old_duty_hi", 32'(ctrl_hi[0]), 32'd1);
      repeat (8) step();                 // cnt == 19
      check_eq("t4_pending_hold", 32'(pending), 32'd1);
      step();                            // wrap applied
      check_eq("t4_pending_clr", 32'(pending), 32'd0);
      step();
      check_eq("t4_cs_after_wrap", 32'(cycle_start), 32'd1);
      repeat (20) step();
      measure(40);
      check_eq("t4_hi_cycles", 32'(hi_cnt[0]), 32'd4);
      check_eq("t4_lo_cycles", 32'(lo_cnt[0]), 32'd24);

      // 5: boundaries
      configure(19, pack4(0, 0, 0, 0), pack4(0, 0, 0, 0), 3);
      repeat (10) step();
      measure(40);
      check_eq("t5_duty0_hi", 32'(hi_cnt[0]), 32'd0);
      check_eq("t5_duty0_lo", 32'(lo_cnt[0]), 32'd40);

      configure(19, pack4(20, 20, 20, 20), pack4(0, 0, 0, 0), 3);
      repeat (3) step();
      check_eq("t5_full_hi_wait", 32'(ctrl_hi), 32'd0);
      step();
      check_eq("t5_full_hi_after_dt", 32'(ctrl_hi), 32'hF);
      measure(40);
      check_eq("t5_full_hi", 32'(hi_cnt[0]), 32'd40);
      check_eq("t5_full_lo", 32'(lo_cnt[0]), 32'd0);

      configure(19, pack4(10, 10, 10, 10), pack4(0, 0, 0, 0), 12);
      repeat (10) step();
      measure(40);
      check_eq("t5_bigdt_hi", 32'(hi_cnt[0]), 32'd0);
      check_eq("t5_bigdt_lo", 32'(lo_cnt[0]), 32'd0);

      // 6: en drop and async reset mid-pulse
      configure(19, pack4(10, 10, 10, 10), pack4(0, 0, 0, 0), 3);
      wait_hi0("t6_wait_hi");
      en = 1'b0;
      step();
      check_eq("t6_en_drop_hi", 32'(ctrl_hi), 32'd0);
      check_eq("t6_en_drop_lo", 32'(ctrl_lo), 32'd0);
      repeat (2) step();
      en = 1'b1;
      step();
      check_eq("t6_restart_cs", 32'(cycle_start), 32'd1);
      check_eq("t6_restart_lo", 32'(ctrl_lo), 32'd0);
      step();
      check_eq("t6_restart_cs_pulse", 32'(cycle_start), 32'd0);
      step();
      check_eq("t6_restart_dt_hold", 32'(ctrl_hi), 32'd0);
      step();
      check_eq("t6_restart_hi", 32'(ctrl_hi), 32'hF);

      wait_hi0("t6_wait_hi2");
      rst_ni = 1'b0;
      #1;
      check_eq("t6_rst_hi", 32'(ctrl_hi), 32'd0);
      check_eq("t6_rst_lo", 32'(ctrl_lo), 32'd0);
      check_eq("t6_rst_cs", 32'(cycle_start), 32'd0);
      step();
      rst_ni = 1'b1;
      repeat (3) step();
      // Zero config: period 0, duty 0 -> counter parked at 0, low side on.
      check_eq("t6_zero_cfg_lo", 32'(ctrl_lo), 32'hF);
      check_eq("t6_zero_cfg_hi", 32'(ctrl_hi), 32'd0);
      check_eq("t6_zero_cfg_cs", 32'(cycle_start), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
